// File: rtl/veda_pkg.sv
// Shared types and default sizes for the veda instruction memory.
package veda_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 32;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/veda_imem_array.sv
// Instruction storage: one write port, one synchronous read port, no reset.
module veda_imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/veda_imem.sv
// Loadable instruction memory: zeroes itself, accepts a program stream,
// then serves single-cycle-latency fetches with out-of-program faulting.
module veda_imem
    import veda_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              clear,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    output logic [ADDR_W:0]   prog_len,
    output logic              ld_full,
    output logic              busy,
    output state_t            dbg_state
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W:0]   wr_ptr;
    logic              hit_q;
    logic              load_hs;
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;

    // Load handshake: a word transfers on a rising edge where ld_valid and
    // ld_ready are both 1; ld_ready never depends on ld_valid, and a clear
    // in the same cycle cancels the transfer.
    assign ld_ready  = (state == LOAD) && (wr_ptr < DEPTH_L);
    assign load_hs   = ld_valid && ld_ready && !clear;
    assign in_range  = ({1'b0, fetch_addr} < prog_len);
    assign ld_full   = (wr_ptr == DEPTH_L);
    assign busy      = (state == CLEAR);
    assign dbg_state = state;

    // The read port registers every cycle; hit_q masks it so that idle and
    // faulting responses read as zero.
    assign fetch_data = rd_data & {DATA_W{hit_q}};

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        if (reset) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
            end else if (load_hs) begin
                mem_we    = 1'b1;
                mem_waddr = wr_ptr[ADDR_W-1:0];
                mem_wdata = ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= CLEAR;
            clr_ptr     <= '0;
            wr_ptr      <= '0;
            prog_len    <= '0;
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            hit_q       <= 1'b0;
            if (clear && state != CLEAR) begin
                state    <= CLEAR;
                clr_ptr  <= '0;
                wr_ptr   <= '0;
                prog_len <= '0;
            end else begin
                case (state)
                    CLEAR: begin
                        clr_ptr <= clr_ptr + 1'b1;
                        if (clr_ptr == LAST) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (mode) begin
                            state <= RUN;
                        end else begin
                            state    <= LOAD;
                            wr_ptr   <= '0;
                            prog_len <= '0;
                        end
                    end
                    LOAD: begin
                        if (load_hs) begin
                            wr_ptr   <= wr_ptr + 1'b1;
                            prog_len <= prog_len + 1'b1;
                        end
                        if (mode) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!mode) begin
                            state    <= LOAD;
                            wr_ptr   <= '0;
                            prog_len <= '0;
                        end else if (fetch_req) begin
                            fetch_valid <= 1'b1;
                            fetch_fault <= !in_range;
                            hit_q       <= in_range;
                        end
                    end
                    default: state <= CLEAR;
                endcase
            end
        end
    end

    veda_imem_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk    (clk),
        .wr_en  (mem_we),
        .wr_addr(mem_waddr),
        .wr_data(mem_wdata),
        .rd_addr(fetch_addr),
        .rd_data(rd_data)
    );

endmodule
